deint_addr_gen: RTL
===================

# deint_addr_gen

Parametrised write/read address generator for the deinterleaver block RAM. It accepts one code block of m_len soft samples, produces RAM write strobes and addresses at a per-link base offset, then serves read addresses under a request handshake. It supersedes the fixed-width enable generator, adding input stall tolerance, explicit read valid, block-done and error reporting, and parametrised widths.

## Interface
- ADDR_W, 16: width of wr_addr/rd_addr and internal counters
- LEN_W, 13: width of m_len
- BASE_OFS, 0: constant added to every generated address (RAM sub-region placement)

- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- din_vld  in  1  input sample valid; one sample per high cycle
- m_len  in  LEN_W  block length; sampled only when a block is accepted
- rd_req  in  1  read consumer advances one address
- wen  out  1  RAM write enable (registered)
- wr_addr  out  ADDR_W  RAM write address (registered)
- rd_addr  out  ADDR_W  RAM read address (registered)
- rd_vld  out  1  rd_addr is valid (high throughout READ)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last read accepted
- err  out  1  one-cycle pulse: unsupported m_len rejected (macro build only)

## Operation
- Base table (m_len -> base): 288->0, 672->288, 1056->960, 432->2016, 1872->2448, 5616->4320. Any other length -> base 0 (see Configuration).
- States: IDLE, WRITE, TURN, READ.
- IDLE: din_vld=1 accepts a block: len_q<=m_len, base_q<=table(m_len)+BASE_OFS, this cycle is sample 0 (wcnt<=1). If m_len==1 go TURN, else WRITE. m_len==0 is never accepted (stay IDLE, no wen).
- WRITE: each din_vld=1 cycle is one sample, wcnt+1; din_vld=0 stalls (counter holds, wen=0 next cycle). Sample with index len_q-1 -> TURN.
- TURN: one cycle; rcnt<=0, rd_addr<=base_q; -> READ. din_vld ignored.
- READ: rd_vld=1. rd_req=1 accepts current rd_addr: rcnt+1, rd_addr<=base_q+rcnt+1. Accept at rcnt==len_q-1 -> IDLE, done=1 next cycle. din_vld ignored.
- wen(n+1)=1 iff a sample was accepted in cycle n; wr_addr(n+1)=base_q+index of that sample.
- Address arithmetic modulo 2^ADDR_W; sums truncated, no saturation.
- m_len changes after acceptance have no effect until next IDLE acceptance.

## Timing
- Reset values: wen=0, wr_addr=0, rd_addr=0, rd_vld=0, busy=0, done=0, err=0; state IDLE, counters 0.
- Write latency: 1 cycle din_vld -> wen/wr_addr.
- Last sample in cycle n: wen at n+1 with last address, TURN at n+1, READ/rd_vld=1 at n+2 with rd_addr=base_q.
- Read: address for accept k presented before rd_req; next address one cycle after accept; back-to-back rd_req gives one address per cycle.
- done asserted one cycle after last accept, coincident with busy=0; a din_vld in that same cycle starts a new block.
- Reset mid-block: all outputs to reset values immediately (async), block discarded.

## Configuration
- DEINT_LEN_CHECK_EN defined: in IDLE, din_vld=1 with m_len not in table -> block rejected, stay IDLE, err=1 next cycle for one cycle, no wen; following din_vld cycles re-evaluated each cycle.
- Undefined: unknown lengths accepted with base 0 (+BASE_OFS); err tied 0.

## Test plan
- m_len=288, din_vld high 288 cycles, rd_req constant 1 -> wen 288 cycles, wr_addr 0..287; rd_addr 0..287; done one cycle after 288th accept.
- m_len=1056, din_vld with a 3-cycle gap after sample 100 -> wen low 3 cycles, wr_addr 960..2015 contiguous, no skipped or repeated address.
- m_len=5616, rd_req toggling 1/0 -> rd_addr 4320..9935, each held until accepted; rd_vld stays 1 through READ.
- m_len changed to 432 mid-WRITE of 672 block -> addresses 288..959, length 672 honoured; next block uses 2016 base.
- n_rst pulsed in READ at rcnt=10 -> outputs 0, busy 0; fresh 432 block then completes normally from 2016.
- m_len=500 with DEINT_LEN_CHECK_EN -> err pulse, no wen, busy stays 0; without macro -> wr_addr 0..499.

Source files
------------

// File: rtl/deint_addr_gen.sv
// Write/read address generator for the deinterleaver block RAM: accepts one code block,
// emits write strobes/addresses at a per-length base, then serves read addresses on request.
// Optional build macro DEINT_LEN_CHECK_EN rejects unsupported block lengths with an err pulse.
module deint_addr_gen #(
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 13,
    parameter int BASE_OFS = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              din_vld,
    input  logic [LEN_W-1:0]  m_len,
    input  logic              rd_req,
    output logic              wen,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_vld,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WRITE, TURN, READ} state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] rcnt_q;
    logic              wen_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic              done_q;

    logic              accept_d;
    logic [ADDR_W-1:0] new_base_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] last_idx_d;

    // RAM sub-region start for each supported code block length; unknown lengths map to 0.
    function automatic logic [ADDR_W-1:0] tableBase(input logic [LEN_W-1:0] len);
        case (len)
            LEN_W'(288):  tableBase = ADDR_W'(0);
            LEN_W'(672):  tableBase = ADDR_W'(288);
            LEN_W'(1056): tableBase = ADDR_W'(960);
            LEN_W'(432):  tableBase = ADDR_W'(2016);
            LEN_W'(1872): tableBase = ADDR_W'(2448);
            LEN_W'(5616): tableBase = ADDR_W'(4320);
            default:      tableBase = ADDR_W'(0);
        endcase
    endfunction

`ifdef DEINT_LEN_CHECK_EN
    function automatic logic inTable(input logic [LEN_W-1:0] len);
        case (len)
            LEN_W'(288), LEN_W'(672), LEN_W'(1056),
            LEN_W'(432), LEN_W'(1872), LEN_W'(5616): inTable = 1'b1;
            default:                                 inTable = 1'b0;
        endcase
    endfunction

    assign accept_d = inTable(m_len);
`else
    assign accept_d = (m_len != '0);
`endif

    assign new_base_d = tableBase(m_len) + ADDR_W'(BASE_OFS);
    assign wr_addr_d  = base_q + wcnt_q;
    assign rd_addr_d  = base_q + rcnt_q + ADDR_W'(1);
    assign last_idx_d = ADDR_W'(len_q) - ADDR_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            base_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wen_q     <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The accepting cycle already carries sample 0 of the block.
                    if (din_vld && accept_d) begin
                        len_q     <= m_len;
                        base_q    <= new_base_d;
                        wcnt_q    <= ADDR_W'(1);
                        wen_q     <= 1'b1;
                        wr_addr_q <= new_base_d;
                        state_q   <= (m_len == LEN_W'(1)) ? TURN : WRITE;
                    end
                end
                WRITE: begin
                    if (din_vld) begin
                        wen_q     <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wcnt_q    <= wcnt_q + ADDR_W'(1);
                        if (wcnt_q == last_idx_d) begin
                            state_q <= TURN;
                        end
                    end
                end
                TURN: begin
                    rcnt_q    <= '0;
                    rd_addr_q <= base_q;
                    rd_vld_q  <= 1'b1;
                    state_q   <= READ;
                end
                READ: begin
                    if (rd_req) begin
                        rcnt_q    <= rcnt_q + ADDR_W'(1);
                        rd_addr_q <= rd_addr_d;
                        if (rcnt_q == last_idx_d) begin
                            rd_vld_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DEINT_LEN_CHECK_EN
    logic err_q;

    // Every rejected din_vld cycle in IDLE is reported on its own; nothing is latched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && din_vld && !accept_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wen     = wen_q;
    assign wr_addr = wr_addr_q;
    assign rd_addr = rd_addr_q;
    assign rd_vld  = rd_vld_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule
